j1708_tx_access_ctrl: RTL and testbench
=======================================

// Module: j1708_tx_access_ctrl
// PURPOSE
//  Sequences one J1708 message transmission: bus access, MID collision check, retry, byte streaming.
//  Sits between the TX message buffer and the UART transmitter.
//  Drives tx_message_process so J1708_RX_SM ignores our own echoed message.
//  Uses the shared bit tick and line-idle detector.
// PARAMETERS
//  MAX_RETRY     3   collision retries before giving up (1..15)
//  ECHO_TIMEOUT  20  bit ticks to wait for the echo of a sent byte before declaring a collision
// PORTS
//  clk                  in   1  system clock
//  rst                  in   1  synchronous reset, active-high
//  enable               in   1  module enable; low = synchronous abort to RESET, outputs cleared
//  bit_tick             in   1  one-cycle pulse per J1708 bit time (9600 Bd)
//  J1708_line_idle      in   1  bus idle (>=10 bit times recessive)
//  tx_request           in   1  level; message ready in buffer
//  tx_priority          in   3  message priority; 0 is treated as 8
//  tx_length            in   8  message length in bytes incl. MID
//  tx_byte_addr         out  8  buffer read address
//  tx_byte_data         in   8  buffer data; valid 1 clk after tx_byte_addr changes
//  uart_tx_byte         out  8  byte to UART
//  uart_tx_start        out  1  one-cycle start pulse
//  uart_tx_busy         in   1  UART shifting
//  J1708_rx_byte        in   8  received (echo) byte
//  J1708_rx_byte_valid  in   1  echo byte strobe
//  tx_message_process   out  1  high from request accept to tx_done/tx_fail
//  tx_done              out  1  one-cycle pulse: message fully sent
//  tx_fail              out  1  one-cycle pulse: retries exhausted, bad length, or echo timeout on last retry
//  retry_count          out  4  collisions seen for the current message
// BEHAVIOUR
//  Reset (rst, or !enable): state RESET; all outputs 0; counters 0.
//  States:
//   RESET: go to IDLE when J1708_line_idle.
//   IDLE: on tx_request, latch priority P (P=0 -> 8) and length L.
//    L<2: tx_fail pulse next clk; stay IDLE; tx_message_process stays 0.
//    Else: tx_message_process<=1, retry_count<=0, go to WAIT_BUS.
//   WAIT_BUS: go to PRIO_DLY when J1708_line_idle.
//   PRIO_DLY: count 2*P bit_ticks, then LOAD with addr 0.
//    Line goes non-idle during the count: return to WAIT_BUS; no retry increment.
//   LOAD: tx_byte_addr stable; next clk capture tx_byte_data into uart_tx_byte.
//    Go to SEND.
//   SEND: when !uart_tx_busy, one-cycle uart_tx_start pulse; go to ECHO.
//   ECHO: wait for J1708_rx_byte_valid; timeout counter runs on bit_tick.
//    Byte 0 (MID), echo == sent: continue.
//    Byte 0 (MID), echo != sent, or timeout: COLLIDE.
//    Bytes >0: echo accepted without compare (see CONFIGURATION).
//    Then addr+1: if addr+1 == L go to DONE, else LOAD.
//   COLLIDE: retry_count+1. If the new count == MAX_RETRY go to FAIL, else WAIT_BUS (MID resent).
//   DONE: tx_done pulse; tx_message_process<=0; go to IDLE.
//   FAIL: tx_fail pulse; tx_message_process<=0; go to IDLE.
//  tx_request is sampled only in IDLE. tx_request still high after DONE starts a new message.
//  Echo strobe arriving in the same clk as a timeout expiry: the echo wins.
//  All counters saturate; tx_byte_addr never exceeds L-1.
//  Latency: last echo strobe -> tx_done is 2 clks.
// CONFIGURATION
//  J1708_TX_ECHO_CHECK_ALL_EN defined:
//   Every byte's echo is compared.
//   Any mismatch or timeout goes to COLLIDE. The whole message is retried from the MID.
//  Not defined: only the MID echo is compared; later bytes need only an echo strobe.
//   A timeout on a later byte still goes to COLLIDE.
// TESTING
//  1. P=2, L=3, idle bus, echo loopback:
//     4 bit_ticks after idle, 3 uart_tx_start pulses, tx_done; retry_count=0.
//  2. MID 0x80 sent, echo 0x7F:
//     COLLIDE, retry_count=1; waits for line_idle; MID resent.
//  3. Echo forced to mismatch on every MID, MAX_RETRY=3:
//     exactly 3 MID sends, then tx_fail; tx_message_process falls in the same clk as tx_fail.
//  4. Line non-idle at priority tick 3 of 4: back to WAIT_BUS, retry_count unchanged.
//     tx_length=1: tx_fail next clk, no uart_tx_start.
//  5. enable dropped mid-message at byte 2: next clk all outputs 0, state RESET, no tx_done.
//  6. With J1708_TX_ECHO_CHECK_ALL_EN, byte 2 echo corrupted: retry from MID.
//     Without the macro: tx_done.

Source files
------------

// File: rtl/j1708_tx_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// j1708_tx_access_ctrl_if
//   Bundles every non-clock/reset signal of the J1708 transmit access
//   controller: the TX message buffer port, the UART transmitter port, the
//   echo receive port, the shared bus-timing inputs and the status outputs.
//
//   master : controller side (j1708_tx_access_ctrl)
//   slave  : environment side (buffer, UART, receiver, bus timing)
//
//   enable               module enable; low aborts to RESET
//   bit_tick             one-cycle pulse per J1708 bit time
//   J1708_line_idle      bus idle (>=10 bit times recessive)
//   tx_request           level: a message is ready in the buffer
//   tx_priority[2:0]     message priority (0 treated as 8)
//   tx_length[7:0]       message length in bytes including MID
//   tx_byte_addr[7:0]    buffer read address
//   tx_byte_data[7:0]    buffer read data, valid 1 clk after address change
//   uart_tx_byte[7:0]    byte handed to the UART
//   uart_tx_start        one-cycle UART start pulse
//   uart_tx_busy         UART is shifting
//   J1708_rx_byte[7:0]   received (echo) byte
//   J1708_rx_byte_valid  echo byte strobe
//   tx_message_process   high while a message is being transmitted
//   tx_done              one-cycle pulse: message fully sent
//   tx_fail              one-cycle pulse: message abandoned
//   retry_count[3:0]     collisions seen for the current message
// ---------------------------------------------------------------------------
interface j1708_tx_access_ctrl_if;
  logic       enable;
  logic       bit_tick;
  logic       J1708_line_idle;
  logic       tx_request;
  logic [2:0] tx_priority;
  logic [7:0] tx_length;
  logic [7:0] tx_byte_addr;
  logic [7:0] tx_byte_data;
  logic [7:0] uart_tx_byte;
  logic       uart_tx_start;
  logic       uart_tx_busy;
  logic [7:0] J1708_rx_byte;
  logic       J1708_rx_byte_valid;
  logic       tx_message_process;
  logic       tx_done;
  logic       tx_fail;
  logic [3:0] retry_count;

  modport master (
    input  enable, bit_tick, J1708_line_idle, tx_request, tx_priority,
           tx_length, tx_byte_data, uart_tx_busy, J1708_rx_byte,
           J1708_rx_byte_valid,
    output tx_byte_addr, uart_tx_byte, uart_tx_start, tx_message_process,
           tx_done, tx_fail, retry_count
  );

  modport slave (
    output enable, bit_tick, J1708_line_idle, tx_request, tx_priority,
           tx_length, tx_byte_data, uart_tx_busy, J1708_rx_byte,
           J1708_rx_byte_valid,
    input  tx_byte_addr, uart_tx_byte, uart_tx_start, tx_message_process,
           tx_done, tx_fail, retry_count
  );
endinterface

// File: rtl/j1708_tx_access_ctrl.sv
// ---------------------------------------------------------------------------
// j1708_tx_access_ctrl
//   Sequences one J1708 message transmission between the TX message buffer
//   and the UART transmitter: waits for an idle bus, applies the 2*P bit-time
//   priority delay, streams the bytes one at a time, checks the echo of each
//   byte and retries the whole message from the MID on a collision.
//   tx_message_process is held high for the whole attempt so the receive
//   state machine can ignore our own echoed message.
//
// Ports
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   j1708_tx_access_ctrl_if.master (see interface file for signals)
//
// Parameters
//   MAX_RETRY     collisions tolerated before tx_fail (1..15)
//   ECHO_TIMEOUT  bit ticks to wait for a byte's echo before a collision
//
// Build option
//   J1708_TX_ECHO_CHECK_ALL_EN : when defined every echoed byte is compared
//   with the sent byte; otherwise only the MID echo is compared and later
//   bytes only need an echo strobe.
// ---------------------------------------------------------------------------
module j1708_tx_access_ctrl #(
  parameter int MAX_RETRY    = 3,
  parameter int ECHO_TIMEOUT = 20
) (
  input logic                    clk,
  input logic                    rst,
  j1708_tx_access_ctrl_if.master bus
);

  localparam int              TO_W        = $clog2(ECHO_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT    = TO_W'(ECHO_TIMEOUT);
  localparam logic [3:0]      RETRY_LIMIT = 4'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_RESET, S_IDLE, S_WAIT_BUS, S_PRIO_DLY, S_LOAD,
    S_SEND, S_ECHO, S_COLLIDE, S_DONE, S_FAIL
  } state_t;

  state_t          state_q, state_nxt;
  logic [3:0]      prio_q, prio_nxt;          // effective priority 1..8
  logic [7:0]      len_q, len_nxt;
  logic [4:0]      prio_cnt_q, prio_cnt_nxt;  // bit ticks spent in priority delay
  logic [TO_W-1:0] to_cnt_q, to_cnt_nxt;      // bit ticks spent waiting for echo
  logic            load_wait_q, load_wait_nxt;
  logic [7:0]      addr_q, addr_nxt;
  logic [7:0]      byte_q, byte_nxt;
  logic [3:0]      retry_q, retry_nxt;
  logic            tmp_q, tmp_nxt;
  logic            start_q, start_nxt;
  logic            done_q, done_nxt;
  logic            fail_q, fail_nxt;
  logic            cmp_en;
  logic            last_byte;

  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'h1f) ? v : v + 5'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

  function automatic logic [TO_W-1:0] sat_inc_to(input logic [TO_W-1:0] v);
    return (v == {TO_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_nxt     = state_q;
    prio_nxt      = prio_q;
    len_nxt       = len_q;
    prio_cnt_nxt  = prio_cnt_q;
    to_cnt_nxt    = to_cnt_q;
    load_wait_nxt = load_wait_q;
    addr_nxt      = addr_q;
    byte_nxt      = byte_q;
    retry_nxt     = retry_q;
    tmp_nxt       = tmp_q;
    start_nxt     = 1'b0;
    done_nxt      = 1'b0;
    fail_nxt      = 1'b0;
`ifdef J1708_TX_ECHO_CHECK_ALL_EN
    cmp_en        = 1'b1;
`else
    cmp_en        = (addr_q == 8'd0);
`endif
    // addr never exceeds L-1, so addr+1 cannot wrap here
    last_byte     = ((addr_q + 8'd1) == len_q);

    case (state_q)
      S_RESET: begin
        if (bus.J1708_line_idle) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (bus.tx_request) begin
          prio_nxt = (bus.tx_priority == 3'd0) ? 4'd8 : {1'b0, bus.tx_priority};
          len_nxt  = bus.tx_length;
          if (bus.tx_length < 8'd2) begin
            // a message needs at least MID + one byte; reject without bus access
            fail_nxt = 1'b1;
          end else begin
            tmp_nxt   = 1'b1;
            retry_nxt = 4'd0;
            addr_nxt  = 8'd0;
            state_nxt = S_WAIT_BUS;
          end
        end
      end
      S_WAIT_BUS: begin
        if (bus.J1708_line_idle) begin
          prio_cnt_nxt = 5'd0;
          state_nxt    = S_PRIO_DLY;
        end
      end
      S_PRIO_DLY: begin
        // losing the idle bus restarts arbitration but is not a collision
        if (!bus.J1708_line_idle) begin
          state_nxt = S_WAIT_BUS;
        end else if (bus.bit_tick) begin
          prio_cnt_nxt = sat_inc5(prio_cnt_q);
          if (prio_cnt_nxt == {prio_q, 1'b0}) begin
            addr_nxt      = 8'd0;
            load_wait_nxt = 1'b0;
            state_nxt     = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        // first cycle lets the buffer read settle, second captures the byte
        if (!load_wait_q) begin
          load_wait_nxt = 1'b1;
        end else begin
          load_wait_nxt = 1'b0;
          byte_nxt      = bus.tx_byte_data;
          state_nxt     = S_SEND;
        end
      end
      S_SEND: begin
        if (!bus.uart_tx_busy) begin
          start_nxt  = 1'b1;
          to_cnt_nxt = '0;
          state_nxt  = S_ECHO;
        end
      end
      S_ECHO: begin
        // an echo strobe takes precedence over a timeout in the same cycle
        if (bus.J1708_rx_byte_valid) begin
          if (cmp_en && (bus.J1708_rx_byte != byte_q)) begin
            state_nxt = S_COLLIDE;
          end else if (last_byte) begin
            state_nxt = S_DONE;
          end else begin
            addr_nxt      = addr_q + 8'd1;
            load_wait_nxt = 1'b0;
            state_nxt     = S_LOAD;
          end
        end else if (bus.bit_tick) begin
          to_cnt_nxt = sat_inc_to(to_cnt_q);
          if (to_cnt_nxt >= TO_LIMIT) state_nxt = S_COLLIDE;
        end
      end
      S_COLLIDE: begin
        retry_nxt = sat_inc4(retry_q);
        state_nxt = (retry_nxt >= RETRY_LIMIT) ? S_FAIL : S_WAIT_BUS;
      end
      S_DONE: begin
        done_nxt  = 1'b1;
        tmp_nxt   = 1'b0;
        state_nxt = S_IDLE;
      end
      S_FAIL: begin
        fail_nxt  = 1'b1;
        tmp_nxt   = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_RESET;
    endcase
  end

  // dropping enable behaves exactly like reset
  always_ff @(posedge clk) begin
    if (rst || !bus.enable) begin
      state_q     <= S_RESET;
      prio_q      <= 4'd0;
      len_q       <= 8'd0;
      prio_cnt_q  <= 5'd0;
      to_cnt_q    <= '0;
      load_wait_q <= 1'b0;
      addr_q      <= 8'd0;
      byte_q      <= 8'd0;
      retry_q     <= 4'd0;
      tmp_q       <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      prio_q      <= prio_nxt;
      len_q       <= len_nxt;
      prio_cnt_q  <= prio_cnt_nxt;
      to_cnt_q    <= to_cnt_nxt;
      load_wait_q <= load_wait_nxt;
      addr_q      <= addr_nxt;
      byte_q      <= byte_nxt;
      retry_q     <= retry_nxt;
      tmp_q       <= tmp_nxt;
      start_q     <= start_nxt;
      done_q      <= done_nxt;
      fail_q      <= fail_nxt;
    end
  end

  assign bus.tx_byte_addr       = addr_q;
  assign bus.uart_tx_byte       = byte_q;
  assign bus.uart_tx_start      = start_q;
  assign bus.tx_message_process = tmp_q;
  assign bus.tx_done            = done_q;
  assign bus.tx_fail            = fail_q;
  assign bus.retry_count        = retry_q;

endmodule

// File: tb/tb_j1708_tx_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_j1708_tx_access_ctrl
//   Scoreboard bench for j1708_tx_access_ctrl. Each directed test queues the
//   UART start bytes and the final done/fail event it expects; a monitor
//   pops and compares whenever the controller presents one of those events.
//   A UART/echo model loops sent bytes back with optional corruption or loss.
// ---------------------------------------------------------------------------
module tb_j1708_tx_access_ctrl;

  localparam int K_START = 0;
  localparam int K_DONE  = 1;
  localparam int K_FAIL  = 2;

  typedef struct {
    int kind;
    int val;       // byte for START, retry_count for DONE/FAIL
    int prev_tmp;  // tx_message_process in the cycle before DONE/FAIL
  } evt_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  j1708_tx_access_ctrl_if bus();

  j1708_tx_access_ctrl #(.MAX_RETRY(3), .ECHO_TIMEOUT(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  evt_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] mem [0:7];
  logic [7:0] mid_mask  = 8'h00;
  int         once_idx  = -1;
  logic [7:0] once_mask = 8'h00;
  int         drop_idx  = -1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push(input int kind, input int val, input int prev_tmp);
    evt_t e;
    e.kind = kind; e.val = val; e.prev_tmp = prev_tmp;
    exp_q.push_back(e);
  endtask

  // bit tick: one pulse every 4 clocks
  initial begin
    bus.bit_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.bit_tick = 1'b1;
      @(negedge clk);
      bus.bit_tick = 1'b0;
    end
  end

  // buffer read port: data follows the address one full clock later
  initial begin
    logic [7:0] addr_d;
    addr_d = 8'd0;
    bus.tx_byte_data = 8'd0;
    forever begin
      @(negedge clk);
      bus.tx_byte_data = mem[addr_d[2:0]];
      addr_d = bus.tx_byte_addr;
    end
  end

  // UART + bus echo model
  initial begin
    logic [7:0] sent, mask;
    int idx;
    bus.uart_tx_busy = 1'b0;
    bus.J1708_rx_byte = 8'd0;
    bus.J1708_rx_byte_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.uart_tx_start) begin
        sent = bus.uart_tx_byte;
        idx  = int'(bus.tx_byte_addr);
        bus.uart_tx_busy = 1'b1;
        repeat (6) @(negedge clk);
        bus.uart_tx_busy = 1'b0;
        mask = (idx == 0) ? mid_mask : 8'h00;
        if (idx == once_idx) begin
          mask = mask ^ once_mask;
          once_idx = -1;
        end
        if (idx == drop_idx) begin
          drop_idx = -1;
        end else begin
          bus.J1708_rx_byte = sent ^ mask;
          bus.J1708_rx_byte_valid = 1'b1;
          @(negedge clk);
          bus.J1708_rx_byte_valid = 1'b0;
        end
      end
    end
  end

  // monitor: pops one expectation per presented event
  task automatic observe(input int kind, input int val, input int tmp_now, input int tmp_prev);
    evt_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: kind %0d value %0h with nothing queued", kind, val);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_value", val, e.val);
      if (kind != K_START) begin
        check("tmp_low_with_end_pulse", tmp_now, 0);
        check("tmp_before_end_pulse", tmp_prev, e.prev_tmp);
      end
    end
  endtask

  initial begin
    int last_tmp;
    last_tmp = 0;
    forever begin
      @(negedge clk);
      if (bus.uart_tx_start) observe(K_START, int'(bus.uart_tx_byte), 0, 0);
      if (bus.tx_done) observe(K_DONE, int'(bus.retry_count), int'(bus.tx_message_process), last_tmp);
      if (bus.tx_fail) observe(K_FAIL, int'(bus.retry_count), int'(bus.tx_message_process), last_tmp);
      last_tmp = int'(bus.tx_message_process);
    end
  end

  task automatic start_msg(input int p, input int l);
    int k;
    bus.tx_priority = 3'(p);
    bus.tx_length   = 8'(l);
    bus.tx_request  = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.tx_message_process && k < 20);
    bus.tx_request = 1'b0;
    check("request_accepted", int'(bus.tx_message_process), 1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin @(negedge clk); k++; end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (12) @(negedge clk);
  endtask

  // raise line idle in a tick cycle, then count ticks until the first start
  task automatic prio_window(output int n);
    int k;
    k = 0; n = 0;
    do begin @(negedge clk); #1; k++; end while (!bus.bit_tick && k < 50);
    bus.J1708_line_idle = 1'b1;
    k = 0;
    while (k < 400) begin
      @(negedge clk); #1; k++;
      if (bus.uart_tx_start) break;
      if (bus.bit_tick) n++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, k;
    mem[0] = 8'h80; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
    mem[4] = 8'h44; mem[5] = 8'h55; mem[6] = 8'h66; mem[7] = 8'h77;
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.J1708_line_idle = 1'b0;
    bus.tx_request = 1'b0;
    bus.tx_priority = 3'd2;
    bus.tx_length = 8'd3;
    repeat (3) @(negedge clk);

    check("reset_addr", int'(bus.tx_byte_addr), 0);
    check("reset_uart_byte", int'(bus.uart_tx_byte), 0);
    check("reset_start", int'(bus.uart_tx_start), 0);
    check("reset_tmp", int'(bus.tx_message_process), 0);
    check("reset_done", int'(bus.tx_done), 0);
    check("reset_fail", int'(bus.tx_fail), 0);
    check("reset_retry", int'(bus.retry_count), 0);
    rst = 1'b0;
    bus.J1708_line_idle = 1'b1;
    repeat (3) @(negedge clk);
    bus.J1708_line_idle = 1'b0;

    // 1: P=2, L=3, clean loopback
    push(K_START, 'h80, 0); push(K_START, 'h11, 0); push(K_START, 'h22, 0);
    push(K_DONE, 0, 1);
    start_msg(2, 3);
    prio_window(n);
    check("prio_ticks_p2", n, 4);
    wait_drain("drain_basic", 2000);

    // 4a: line lost after 2 of 4 priority ticks restarts the delay
    bus.J1708_line_idle = 1'b0;
    push(K_START, 'h80, 0); push(K_START, 'h11, 0); push(K_START, 'h22, 0);
    push(K_DONE, 0, 1);
    start_msg(2, 3);
    k = 0;
    do begin @(negedge clk); #1; k++; end while (!bus.bit_tick && k < 50);
    bus.J1708_line_idle = 1'b1;
    n = 0; k = 0;
    while (n < 2 && k < 100) begin @(negedge clk); #1; k++; if (bus.bit_tick) n++; end
    @(negedge clk); #1;
    bus.J1708_line_idle = 1'b0;
    repeat (5) @(negedge clk);
    check("no_start_while_line_busy", int'(bus.tx_message_process), 1);
    prio_window(n);
    check("prio_ticks_after_restart", n, 4);
    wait_drain("drain_prio_restart", 2000);

    // 4b: tx_length=1 -> tx_fail next clk, no start
    push(K_FAIL, 0, 0);
    bus.tx_length = 8'd1;
    bus.tx_request = 1'b1;
    @(negedge clk);
    bus.tx_request = 1'b0;
    check("short_len_fail_next_clk", int'(bus.tx_fail), 1);
    wait_drain("drain_short_len", 50);

    // 2: MID 0x80 echoed as 0x7F once -> one collision then success
    once_idx = 0; once_mask = 8'hFF;
    push(K_START, 'h80, 0); push(K_START, 'h80, 0); push(K_START, 'h11, 0);
    push(K_START, 'h22, 0); push(K_DONE, 1, 1);
    start_msg(2, 3);
    wait_drain("drain_mid_collision", 3000);

    // 3: every MID echo corrupted -> 3 MID sends then tx_fail
    mid_mask = 8'hFF;
    push(K_START, 'h80, 0); push(K_START, 'h80, 0); push(K_START, 'h80, 0);
    push(K_FAIL, 3, 1);
    start_msg(2, 3);
    wait_drain("drain_retry_exhaust", 3000);
    mid_mask = 8'h00;

    // echo of byte 1 lost -> timeout collision, whole message resent
    drop_idx = 1;
    push(K_START, 'h80, 0); push(K_START, 'h11, 0);
    push(K_START, 'h80, 0); push(K_START, 'h11, 0); push(K_START, 'h22, 0);
    push(K_DONE, 1, 1);
    start_msg(1, 3);
    wait_drain("drain_echo_timeout", 3000);

    // 6: byte 2 echo corrupted
    once_idx = 2; once_mask = 8'h01;
    push(K_START, 'h80, 0); push(K_START, 'h11, 0); push(K_START, 'h22, 0);
`ifdef J1708_TX_ECHO_CHECK_ALL_EN
    push(K_START, 'h80, 0); push(K_START, 'h11, 0); push(K_START, 'h22, 0);
    push(K_DONE, 1, 1);
`else
    push(K_DONE, 0, 1);
`endif
    start_msg(2, 3);
    wait_drain("drain_late_byte_corrupt", 3000);
    once_idx = -1;

    // 5: enable dropped while byte 2 is on the wire
    push(K_START, 'h80, 0); push(K_START, 'h11, 0); push(K_START, 'h22, 0);
    start_msg(2, 4);
    k = 0;
    do begin @(negedge clk); #1; k++; end
      while (!(bus.uart_tx_start && bus.tx_byte_addr == 8'd2) && k < 2000);
    check("abort_reached_byte2", int'(bus.tx_byte_addr), 2);
    bus.enable = 1'b0;
    @(negedge clk); #1;
    check("abort_addr", int'(bus.tx_byte_addr), 0);
    check("abort_uart_byte", int'(bus.uart_tx_byte), 0);
    check("abort_tmp", int'(bus.tx_message_process), 0);
    check("abort_retry", int'(bus.retry_count), 0);
    repeat (40) @(negedge clk);
    check("abort_no_further_events", exp_q.size(), 0);
    bus.enable = 1'b1;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
